inst_cache_ctrl: RTL and testbench

INST_CACHE_CTRL -- requirements
Module: inst_cache_ctrl

---
 rtl/inst_cache_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_inst_cache_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_cache_ctrl.sv
// inst_cache_ctrl -- direct-mapped instruction cache controller.
// Drives an external tag RAM (combinational read) and data RAM. Lookup hits
// complete in zero cycles. Misses invalidate the line first, then refill it
// word by word from memory and finally mark it valid. This ordering means
// an abandoned refill can never leave a partially filled line that hits.
// Optional feature macro: ICACHE_FLUSH_EN (invalidate-all via the flush
// input). Without it, flush is ignored.
// Address split: {tag, index, word offset, 2'b00}; the tag spans
// `ITAGMSB:`ITAGLSB of the fetch address.

`ifndef ICACHE_INDEX
`define ICACHE_INDEX 4
`endif
`ifndef ICACHE_SIZE
`define ICACHE_SIZE 16
`endif

module inst_cache_ctrl #(
   parameter  int ADDR_W  = 32,
   parameter  int INDEX_W = `ICACHE_INDEX,
   parameter  int OFF_W   = 2,
   localparam int TAG_W   = ADDR_W - INDEX_W - OFF_W - 2
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     cpu_req,
   input  logic [ADDR_W-1:0]        cpu_addr,
   output logic                     cpu_ready,
   output logic [INDEX_W-1:0]       tag_index,
   output logic                     tag_we,
   output logic                     tag_valid_in,
   output logic [TAG_W-1:0]         tag_in,
   input  logic                     tag_valid_out,
   input  logic [TAG_W-1:0]         tag_out,
   output logic [INDEX_W+OFF_W-1:0] data_addr,
   output logic                     data_we,
   output logic [31:0]              data_wdata,
   output logic                     mem_req,
   output logic [ADDR_W-1:0]        mem_addr,
   input  logic                     mem_ack,
   input  logic [31:0]              mem_rdata,
   input  logic                     flush
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REFILL = 2'd1,
      UPDATE = 2'd2
`ifdef ICACHE_FLUSH_EN
      ,
      FLUSH  = 2'd3
`endif
   } state_t;

   localparam logic [OFF_W-1:0] CNT_LAST = '1;

   state_t             state_r, state_nxt_s;
   logic [OFF_W-1:0]   cnt_r, cnt_nxt_s;
   logic [TAG_W-1:0]   tag_r, tag_nxt_s;
   logic [INDEX_W-1:0] index_r, index_nxt_s;

   logic [TAG_W-1:0]   cpu_tag_s;
   logic [INDEX_W-1:0] cpu_index_s;
   logic [OFF_W-1:0]   cpu_off_s;
   logic               hit_s;

`ifdef ICACHE_FLUSH_EN
   localparam logic [INDEX_W-1:0] FLUSH_LAST = INDEX_W'(`ICACHE_SIZE - 1);
   logic [INDEX_W-1:0] flush_cnt_r, flush_cnt_nxt_s;
   logic               flush_pend_r, flush_pend_nxt_s;
   logic               unused_addr_s;
   assign unused_addr_s = ^cpu_addr[1:0];
`else
   logic               unused_addr_s;
   assign unused_addr_s = ^{cpu_addr[1:0], flush};
`endif

   assign cpu_tag_s   = cpu_addr[ADDR_W-1 -: TAG_W];
   assign cpu_index_s = cpu_addr[OFF_W+2 +: INDEX_W];
   assign cpu_off_s   = cpu_addr[2 +: OFF_W];
   assign hit_s       = cpu_req & tag_valid_out & (tag_out == cpu_tag_s);

   // Refill address is always built from the latched line and word counter.
   assign mem_addr = {tag_r, index_r, cnt_r, 2'b00};

   // Next-state logic and RAM/CPU/memory port decode for every state.
   always_comb begin
      state_nxt_s  = state_r;
      cnt_nxt_s    = cnt_r;
      tag_nxt_s    = tag_r;
      index_nxt_s  = index_r;
      cpu_ready    = 1'b0;
      tag_index    = index_r;
      tag_we       = 1'b0;
      tag_valid_in = 1'b0;
      tag_in       = tag_r;
      data_addr    = {index_r, cnt_r};
      data_we      = 1'b0;
      data_wdata   = mem_rdata;
      mem_req      = 1'b0;
`ifdef ICACHE_FLUSH_EN
      flush_cnt_nxt_s  = flush_cnt_r;
      flush_pend_nxt_s = flush_pend_r;
`endif
      case (state_r)
         IDLE: begin
            tag_index = cpu_index_s;
            data_addr = {cpu_index_s, cpu_off_s};
            tag_in    = cpu_tag_s;
`ifdef ICACHE_FLUSH_EN
            if (flush || flush_pend_r) begin
               state_nxt_s      = FLUSH;
               flush_cnt_nxt_s  = '0;
               flush_pend_nxt_s = 1'b0;
            end else
`endif
            if (!cpu_req) begin
               state_nxt_s = IDLE;
            end else if (hit_s) begin
               cpu_ready = 1'b1;
            end else begin
               // Invalidate the victim line before any data word is overwritten.
               tag_we       = 1'b1;
               tag_valid_in = 1'b0;
               tag_nxt_s    = cpu_tag_s;
               index_nxt_s  = cpu_index_s;
               cnt_nxt_s    = '0;
               state_nxt_s  = REFILL;
            end
         end
         REFILL: begin
            mem_req = 1'b1;
`ifdef ICACHE_FLUSH_EN
            flush_pend_nxt_s = flush_pend_r | flush;
`endif
            if (mem_ack) begin
               data_we   = 1'b1;
               cnt_nxt_s = cnt_r + OFF_W'(1);
               if (cnt_r == CNT_LAST) begin
                  state_nxt_s = UPDATE;
               end else begin
                  state_nxt_s = REFILL;
               end
            end else begin
               state_nxt_s = REFILL;
            end
         end
         UPDATE: begin
            tag_we       = 1'b1;
            tag_valid_in = 1'b1;
            tag_in       = tag_r;
            state_nxt_s  = IDLE;
`ifdef ICACHE_FLUSH_EN
            flush_pend_nxt_s = flush_pend_r | flush;
`endif
         end
`ifdef ICACHE_FLUSH_EN
         FLUSH: begin
            tag_index       = flush_cnt_r;
            tag_we          = 1'b1;
            tag_valid_in    = 1'b0;
            flush_cnt_nxt_s = flush_cnt_r + INDEX_W'(1);
            if (flush_cnt_r == FLUSH_LAST) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = FLUSH;
            end
         end
`endif
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State, word counter and latched line address registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
         cnt_r   <= '0;
         tag_r   <= '0;
         index_r <= '0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         tag_r   <= tag_nxt_s;
         index_r <= index_nxt_s;
      end
   end

`ifdef ICACHE_FLUSH_EN
   // Invalidate-all sweep counter and flush request held while busy.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         flush_cnt_r  <= '0;
         flush_pend_r <= 1'b0;
      end else begin
         flush_cnt_r  <= flush_cnt_nxt_s;
         flush_pend_r <= flush_pend_nxt_s;
      end
   end
`endif

endmodule

// File: tb/tb_inst_cache_ctrl.sv
// tb_inst_cache_ctrl -- directed, table-driven bench for inst_cache_ctrl.
// Provides behavioural tag/data RAMs and a memory with configurable ack
// delay. Expected values come from the vector table and hand sequences.
module tb_inst_cache_ctrl;

   localparam int TAG_W = 24;
   localparam int LINES = 16;

   logic              clock    = 1'b0;
   logic              reset_n  = 1'b0;
   logic              cpu_req  = 1'b0;
   logic [31:0]       cpu_addr = 32'd0;
   logic              flush    = 1'b0;
   logic              cpu_ready;
   logic [3:0]        tag_index;
   logic              tag_we, tag_valid_in, tag_valid_out;
   logic [TAG_W-1:0]  tag_in, tag_out;
   logic [5:0]        data_addr;
   logic              data_we;
   logic [31:0]       data_wdata;
   logic              mem_req, mem_ack;
   logic [31:0]       mem_addr, mem_rdata;

   inst_cache_ctrl #(.ADDR_W(32), .INDEX_W(4), .OFF_W(2)) dut (
      .clock(clock), .reset_n(reset_n),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ready(cpu_ready),
      .tag_index(tag_index), .tag_we(tag_we), .tag_valid_in(tag_valid_in),
      .tag_in(tag_in), .tag_valid_out(tag_valid_out), .tag_out(tag_out),
      .data_addr(data_addr), .data_we(data_we), .data_wdata(data_wdata),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .flush(flush)
   );

   always #5 clock = ~clock;

   // Environment: tag RAM, data RAM, memory
   logic [TAG_W-1:0] tag_mem [LINES];
   logic [LINES-1:0] valid_mem = '0;
   logic [31:0]      data_mem [64];
   int               ack_wait  = 0;
   int               wait_cnt  = 0;
   logic             force_ack = 1'b0;

   assign tag_out       = tag_mem[tag_index];
   assign tag_valid_out = valid_mem[tag_index];
   assign mem_ack       = force_ack | (mem_req & (wait_cnt == ack_wait));
   assign mem_rdata     = mem_addr ^ 32'hA5A5_0000;

   // Monitor counters
   int               n_ack = 0, n_data_we = 0, n_tag_inv = 0, n_tag_val = 0;
   int               n_both = 0, n_unstable = 0;
   logic [TAG_W-1:0] last_val_tag = '0;
   logic [31:0]      ack_log [256];
   logic             waiting = 1'b0;
   logic [31:0]      prev_addr = 32'd0;

   // RAM writes, memory handshake and protocol monitors
   always @(posedge clock) begin
      if (mem_req && mem_ack) begin
         ack_log[n_ack % 256] <= mem_addr;
         n_ack    <= n_ack + 1;
         wait_cnt <= 0;
      end else if (mem_req) begin
         wait_cnt <= wait_cnt + 1;
      end else begin
         wait_cnt <= 0;
      end
      if (data_we) begin
         data_mem[data_addr] <= data_wdata;
         n_data_we <= n_data_we + 1;
      end
      if (tag_we) begin
         tag_mem[tag_index]   <= tag_in;
         valid_mem[tag_index] <= tag_valid_in;
         if (tag_valid_in) begin
            n_tag_val    <= n_tag_val + 1;
            last_val_tag <= tag_in;
         end else begin
            n_tag_inv <= n_tag_inv + 1;
         end
      end
      if (tag_we && data_we) n_both <= n_both + 1;
      if (waiting && mem_req && (mem_addr != prev_addr)) n_unstable <= n_unstable + 1;
      waiting   <= mem_req && !mem_ack;
      prev_addr <= mem_addr;
   end

   int checks = 0;
   int failures = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=0x%08h expected=0x%08h", nm, act, exp);
      end
   endtask

   // One CPU access: checks the lookup cycle, then for a miss the full refill.
   task automatic run_access(input logic [31:0] addr, input logic exp_hit,
                             input logic [31:0] base, input int wcyc, input string nm);
      int ack0, dwe0, inv0, val0, cyc;
      ack_wait = wcyc;
      @(negedge clock);
      ack0 = n_ack; dwe0 = n_data_we; inv0 = n_tag_inv; val0 = n_tag_val;
      cpu_req  = 1'b1;
      cpu_addr = addr;
      #1;
      check({nm, "_lookup_ready"}, 32'(cpu_ready), 32'(exp_hit));
      check({nm, "_data_addr"}, 32'(data_addr), 32'(addr[7:2]));
      if (exp_hit) begin
         check({nm, "_hit_mem_req"}, 32'(mem_req), 32'd0);
         @(posedge clock);
         #1;
         check({nm, "_hit_no_ack"}, 32'(n_ack - ack0), 32'd0);
         check({nm, "_hit_no_dwe"}, 32'(n_data_we - dwe0), 32'd0);
      end else begin
         check({nm, "_inval_we"}, 32'({tag_we, tag_valid_in}), 32'd2);
         cyc = 1;
         while (!cpu_ready && cyc < 200) begin
            @(negedge clock);
            #1;
            cyc++;
         end
         check({nm, "_hit_cycle"}, 32'(cyc), 32'(3 + 4 * (wcyc + 1)));
         check({nm, "_acks"}, 32'(n_ack - ack0), 32'd4);
         for (int i = 0; i < 4; i++) begin
            check({nm, "_mem_addr"}, ack_log[(ack0 + i) % 256], base + 32'(4 * i));
            check({nm, "_data"}, data_mem[{addr[7:4], 2'(i)}], (base + 32'(4 * i)) ^ 32'hA5A5_0000);
         end
         check({nm, "_data_we"}, 32'(n_data_we - dwe0), 32'd4);
         check({nm, "_tag_inv"}, 32'(n_tag_inv - inv0), 32'd1);
         check({nm, "_tag_val"}, 32'(n_tag_val - val0), 32'd1);
         check({nm, "_tag_written"}, 32'(last_val_tag), 32'(addr[31:8]));
      end
      cpu_req = 1'b0;
   endtask

   typedef struct {
      logic [31:0] addr;
      logic        exp_hit;
      logic [31:0] exp_base;
      int          wait_cyc;
   } vec_t;

   vec_t vecs [7];

   initial begin
      int ack0, dwe0, inv0;
      vecs[0] = '{32'h0000_0104, 1'b0, 32'h0000_0100, 0};  // cold miss
      vecs[1] = '{32'h0000_010C, 1'b1, 32'h0000_0100, 0};  // same-line hit
      vecs[2] = '{32'h0000_0134, 1'b0, 32'h0000_0130, 0};  // other index
      vecs[3] = '{32'h0000_0204, 1'b0, 32'h0000_0200, 0};  // tag conflict idx 0
      vecs[4] = '{32'h0000_0100, 1'b0, 32'h0000_0100, 3};  // conflict back, slow mem
      vecs[5] = '{32'h0000_0138, 1'b1, 32'h0000_0130, 0};
      vecs[6] = '{32'h0000_0108, 1'b1, 32'h0000_0100, 0};

      // Reset state
      @(negedge clock);
      #1;
      check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_tag_we", 32'(tag_we), 32'd0);
      check("rst_data_we", 32'(data_we), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      reset_n = 1'b1;

      for (int v = 0; v < 7; v++) begin
         run_access(vecs[v].addr, vecs[v].exp_hit, vecs[v].exp_base, vecs[v].wait_cyc,
                    $sformatf("vec%0d", v));
      end

      // CPU address changes during REFILL are ignored
      ack_wait = 2;
      @(negedge clock);
      ack0 = n_ack;
      cpu_req = 1'b1; cpu_addr = 32'h0000_0454;
      repeat (2) @(negedge clock);
      cpu_addr = 32'h0000_0138;
      #1;
      check("refill_ready_low", 32'(cpu_ready), 32'd0);
      check("refill_mem_addr", mem_addr, 32'h0000_0450);
      check("refill_tag_index", 32'(tag_index), 32'd5);
      cpu_addr = 32'h0000_0454;
      for (int c = 0; c < 60 && !cpu_ready; c++) begin
         @(negedge clock);
         #1;
      end
      check("refill_done_ready", 32'(cpu_ready), 32'd1);
      check("refill_acks", 32'(n_ack - ack0), 32'd4);
      check("refill_last_addr", ack_log[(ack0 + 3) % 256], 32'h0000_045C);
      cpu_req = 1'b0;

      // Reset after the second ack abandons the refill of index 3
      ack_wait = 0;
      @(negedge clock);
      ack0 = n_ack;
      cpu_req = 1'b1; cpu_addr = 32'h0000_0334;
      repeat (3) @(negedge clock);
      check("pre_rst_acks", 32'(n_ack - ack0), 32'd2);
      reset_n = 1'b0;
      cpu_req = 1'b0;
      #1;
      check("mid_rst_mem_req", 32'(mem_req), 32'd0);
      check("mid_rst_we", 32'({tag_we, data_we}), 32'd0);
      check("mid_rst_mem_addr", mem_addr, 32'd0);
      check("mid_rst_line_invalid", 32'(valid_mem[3]), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      run_access(32'h0000_0334, 1'b0, 32'h0000_0330, 0, "post_rst");

      // mem_ack outside REFILL is ignored
      @(negedge clock);
      dwe0 = n_data_we;
      force_ack = 1'b1; cpu_req = 1'b1; cpu_addr = 32'h0000_010C;
      repeat (2) @(negedge clock);
      #1;
      check("stray_ack_no_dwe", 32'(n_data_we - dwe0), 32'd0);
      check("stray_ack_hit", 32'(cpu_ready), 32'd1);
      force_ack = 1'b0; cpu_req = 1'b0;

`ifdef ICACHE_FLUSH_EN
      // Flush in IDLE wins over a hit, then sweeps every line
      @(negedge clock);
      inv0 = n_tag_inv;
      cpu_req = 1'b1; cpu_addr = 32'h0000_010C; flush = 1'b1;
      #1;
      check("flush_prio_ready", 32'(cpu_ready), 32'd0);
      @(negedge clock);
      flush = 1'b0; cpu_req = 1'b0;
      repeat (18) @(negedge clock);
      check("flush_inval_cnt", 32'(n_tag_inv - inv0), 32'(LINES));
      check("flush_all_invalid", 32'(valid_mem), 32'd0);
      run_access(32'h0000_010C, 1'b0, 32'h0000_0100, 0, "after_flush");
`else
      // Flush is ignored
      @(negedge clock);
      inv0 = n_tag_inv;
      cpu_req = 1'b1; cpu_addr = 32'h0000_010C; flush = 1'b1;
      #1;
      check("noflush_ready", 32'(cpu_ready), 32'd1);
      @(negedge clock);
      #1;
      check("noflush_no_inval", 32'(n_tag_inv - inv0), 32'd0);
      flush = 1'b0; cpu_req = 1'b0;
`endif

      @(negedge clock);
      check("never_both_we", 32'(n_both), 32'd0);
      check("mem_addr_stable", 32'(n_unstable), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
